// File: rtl/ps2_key_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ps2_key_decoder
// Description : PS/2 keyboard front end for the game logic block.
//               - Synchronises and deglitches the raw ps2_clk/ps2_data lines.
//               - Deserialises 11-bit frames (start, 8 data LSB first, odd
//                 parity, stop).
//               - Decodes scan-code set 2: E0 (extended) and F0 (break)
//                 prefixes.
//               - Keeps a 512-entry held-key map indexed by {ext, code}.
// Ports       : pclk        in   system clock, all logic on its rising edge
//               rst_n       in   asynchronous active-low reset
//               ps2_clk     in   raw PS/2 clock (asynchronous)
//               ps2_data    in   raw PS/2 data (asynchronous)
//               key_down    out  [511:0] bit {ext,code} set while key held
//               last_change out  [8:0] {ext,code} of latest make/break
//               key_valid   out  one-cycle strobe on key_down/last_change update
//               frame_err   out  one-cycle strobe on start/parity/stop error
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic         pclk,
  input  logic         rst_n,
  input  logic         ps2_clk,
  input  logic         ps2_data,
  output logic [511:0] key_down,
  output logic [8:0]   last_change,
  output logic         key_valid,
  output logic         frame_err
);

  localparam int c_FW = $clog2(FILTER_LEN + 1);
  localparam int c_TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  // Input conditioning
  logic            r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic            r_clk_f, r_clk_f_q;
  logic [c_FW-1:0] r_filt_cnt;
  logic            w_fall;

  // Frame receiver
  state_t          r_state;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_shift;
  logic            r_par;
  logic            r_byte_rdy;
  logic [c_TW-1:0] r_to_cnt;

  // Decoder
  logic            r_ext, r_brk;
  logic            w_ignore;

  // Synchronisers and clock filter. Lines idle high, so the synchroniser
  // stages reset to 1 to avoid a spurious edge after reset release.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
      r_clk_f    <= 1'b1;
      r_clk_f_q  <= 1'b1;
      r_filt_cnt <= '0;
    end else begin
      r_clk_s1  <= ps2_clk;
      r_clk_s2  <= r_clk_s1;
      r_dat_s1  <= ps2_data;
      r_dat_s2  <= r_dat_s1;
      r_clk_f_q <= r_clk_f;
      // Any sample agreeing with the filtered level restarts the run count.
      if (r_clk_s2 != r_clk_f) begin
        if (r_filt_cnt == c_FW'(FILTER_LEN - 1)) begin
          r_clk_f    <= r_clk_s2;
          r_filt_cnt <= '0;
        end else begin
          r_filt_cnt <= r_filt_cnt + 1'b1;
        end
      end else begin
        r_filt_cnt <= '0;
      end
    end
  end

  assign w_fall = r_clk_f_q & ~r_clk_f;

  // Frame FSM: advances once per filtered falling edge.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_byte_rdy <= 1'b0;
      r_to_cnt   <= '0;
      frame_err  <= 1'b0;
    end else begin
      r_byte_rdy <= 1'b0;
      frame_err  <= 1'b0;
      if (w_fall) begin
        r_to_cnt <= '0;
        case (r_state)
          S_IDLE: begin
            if (!r_dat_s2) begin
              r_state   <= S_DATA;
              r_bit_cnt <= '0;
            end else begin
              frame_err <= 1'b1;
            end
          end
          S_DATA: begin
            r_shift <= {r_dat_s2, r_shift[7:1]};
            if (r_bit_cnt == 3'd7) begin
              r_state <= S_PARITY;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
          S_PARITY: begin
            r_par   <= r_dat_s2;
            r_state <= S_STOP;
          end
          S_STOP: begin
            if (r_dat_s2 && (^{r_shift, r_par})) begin
              r_byte_rdy <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end else if (r_state != S_IDLE) begin
        // A stalled partial frame is dropped silently.
        if (r_to_cnt == c_TW'(TIMEOUT_CYCLES - 1)) begin
          r_state  <= S_IDLE;
          r_to_cnt <= '0;
        end else begin
          r_to_cnt <= r_to_cnt + 1'b1;
        end
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

  // Keyboard housekeeping replies (BAT, ACK, resend, echo, errors) are not
  // key events when they arrive without a prefix.
  always_comb begin
    w_ignore = 1'b0;
    case (r_shift)
      8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: w_ignore = ~r_ext & ~r_brk;
      default: w_ignore = 1'b0;
    endcase
  end

  // Scan-code decoder: runs on the cycle after a good stop bit.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_ext       <= 1'b0;
      r_brk       <= 1'b0;
      key_down    <= '0;
      last_change <= '0;
      key_valid   <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (r_byte_rdy) begin
        if (r_shift == 8'hE0) begin
          r_ext <= 1'b1;
        end else if (r_shift == 8'hF0) begin
          r_brk <= 1'b1;
        end else if (!w_ignore) begin
          key_down[{r_ext, r_shift}] <= ~r_brk;
          last_change                <= {r_ext, r_shift};
          key_valid                  <= 1'b1;
          r_ext                      <= 1'b0;
          r_brk                      <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_key_decoder
// Description : Directed self-checking bench for ps2_key_decoder. Drives
//               PS/2 frames bit by bit and checks key map, last code,
//               strobe counts and strobe latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_key_decoder;

  logic         pclk;
  logic         rst_n;
  logic         ps2_clk;
  logic         ps2_data;
  logic [511:0] key_down;
  logic [8:0]   last_change;
  logic         key_valid;
  logic         frame_err;

  ps2_key_decoder #(
    .FILTER_LEN     (8),
    .TIMEOUT_CYCLES (50000)
  ) dut (
    .pclk        (pclk),
    .rst_n       (rst_n),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .key_down    (key_down),
    .last_change (last_change),
    .key_valid   (key_valid),
    .frame_err   (frame_err)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  // Strobe monitor, sampled on the falling edge.
  int   kv_cnt = 0, fe_cnt = 0, kv_cyc = 0;
  int   kv_consec = 0, fe_consec = 0, overlap = 0;
  logic kv_prev = 1'b0, fe_prev = 1'b0;
  always @(negedge pclk) begin
    if (key_valid === 1'b1) begin
      kv_cnt = kv_cnt + 1;
      kv_cyc = cyc;
      if (kv_prev) kv_consec = kv_consec + 1;
    end
    if (frame_err === 1'b1) begin
      fe_cnt = fe_cnt + 1;
      if (fe_prev) fe_consec = fe_consec + 1;
    end
    if (key_valid === 1'b1 && frame_err === 1'b1) overlap = overlap + 1;
    kv_prev = key_valid;
    fe_prev = frame_err;
  end

  int n_cmp  = 0;
  int n_fail = 0;
  int last_fall_cyc = 0;
  int kv_base, fe_base;
  logic [511:0] saved_kd;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    wait_cyc(10);
    ps2_clk = 1'b0;
    last_fall_cyc = cyc;
    wait_cyc(20);
    ps2_clk = 1'b1;
    wait_cyc(10);
  endtask

  // Sends the first n bits of a frame (start, data LSB first, parity, stop).
  task automatic send_bits(input logic [7:0] b, input logic bad_par, input int n);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < n; i++) send_bit(fr[i]);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    send_bits(b, bad_par, 11);
    wait_cyc(30);
  endtask

  task automatic mark();
    kv_base = kv_cnt;
    fe_base = fe_cnt;
  endtask

  initial begin
    rst_n    = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(5);

    // Reset state
    check("rst_key_down",    key_down,    512'd0);
    check("rst_last_change", 512'(last_change), 512'd0);
    check("rst_key_valid",   512'(key_valid),   512'd0);
    check("rst_frame_err",   512'(frame_err),   512'd0);
    rst_n = 1'b1;
    wait_cyc(20);

    // Make Space
    mark();
    send_frame(8'h29, 1'b0);
    check("make_kd029",  512'(key_down[9'h029]), 512'd1);
    check("make_last",   512'(last_change),      512'h029);
    check("make_kv_cnt", 512'(kv_cnt - kv_base), 512'd1);
    check("make_fe_cnt", 512'(fe_cnt - fe_base), 512'd0);
    check("make_latency", 512'(kv_cyc - last_fall_cyc), 512'd12);

    // Break Space
    mark();
    send_frame(8'hF0, 1'b0);
    check("brk_prefix_kv", 512'(kv_cnt - kv_base), 512'd0);
    send_frame(8'h29, 1'b0);
    check("brk_kd029",  512'(key_down[9'h029]), 512'd0);
    check("brk_last",   512'(last_change),      512'h029);
    check("brk_kv_cnt", 512'(kv_cnt - kv_base), 512'd1);

    // Extended make
    mark();
    send_frame(8'hE0, 1'b0);
    send_frame(8'h75, 1'b0);
    check("ext_kd175",  512'(key_down[9'h175]), 512'd1);
    check("ext_kd075",  512'(key_down[9'h075]), 512'd0);
    check("ext_last",   512'(last_change),      512'h175);
    check("ext_kv_cnt", 512'(kv_cnt - kv_base), 512'd1);

    // Parity error then good frame
    mark();
    saved_kd = key_down;
    send_frame(8'h29, 1'b1);
    check("par_fe_cnt", 512'(fe_cnt - fe_base), 512'd1);
    check("par_kv_cnt", 512'(kv_cnt - kv_base), 512'd0);
    check("par_kd",     key_down,               saved_kd);
    send_frame(8'h1C, 1'b0);
    check("par_kd01c",  512'(key_down[9'h01C]), 512'd1);
    check("par_last",   512'(last_change),      512'h01C);

    // Short glitch on the clock line with data high: must not reach the FSM
    mark();
    ps2_data = 1'b1;
    ps2_clk  = 1'b0;
    wait_cyc(3);
    ps2_clk  = 1'b1;
    wait_cyc(40);
    check("glitch_fe", 512'(fe_cnt - fe_base), 512'd0);
    check("glitch_kv", 512'(kv_cnt - kv_base), 512'd0);

    // Five bits then a stall beyond the timeout
    mark();
    send_bits(8'h29, 1'b0, 5);
    ps2_data = 1'b1;
    wait_cyc(60000);
    check("tmo_fe", 512'(fe_cnt - fe_base), 512'd0);
    check("tmo_kv", 512'(kv_cnt - kv_base), 512'd0);
    send_frame(8'h1C, 1'b0);
    check("tmo_kv_after", 512'(kv_cnt - kv_base), 512'd1);
    check("tmo_fe_after", 512'(fe_cnt - fe_base), 512'd0);
    check("tmo_last",     512'(last_change),      512'h01C);
    check("tmo_kd01c",    512'(key_down[9'h01C]), 512'd1);

    // Reset in the middle of a frame while Space is held
    send_frame(8'h29, 1'b0);
    check("mid_pre_kd029", 512'(key_down[9'h029]), 512'd1);
    send_bits(8'h5A, 1'b0, 5);
    rst_n = 1'b0;
    #1;
    check("mid_rst_kd",   key_down,          512'd0);
    check("mid_rst_last", 512'(last_change), 512'd0);
    check("mid_rst_kv",   512'(key_valid),   512'd0);
    check("mid_rst_fe",   512'(frame_err),   512'd0);
    ps2_data = 1'b1;
    wait_cyc(5);
    rst_n = 1'b1;
    wait_cyc(20);
    mark();
    send_frame(8'h29, 1'b0);
    check("mid_after_kd", key_down, 512'd1 << 9'h029);
    check("mid_after_kv", 512'(kv_cnt - kv_base), 512'd1);
    check("mid_after_fe", 512'(fe_cnt - fe_base), 512'd0);

    // Strobe exclusivity over the whole run
    check("kv_fe_overlap", 512'(overlap),   512'd0);
    check("kv_consecutive", 512'(kv_consec), 512'd0);
    check("fe_consecutive", 512'(fe_consec), 512'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
